// File: rtl/snake_body_if.sv
// Snake body bus: the move/start/direction controls, the apple position from the
// score block, the draw-path query, and the head/length/status results.
// The master drives controls and queries; the slave (snake_body) returns results.
interface snake_body_if;
    logic       move_tick;
    logic       start;
    logic       dir_valid;
    logic [1:0] dir_req;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic [6:0] q_x;
    logic [5:0] q_y;
    logic [6:0] head_x;
    logic [5:0] head_y;
    logic [4:0] length;
    logic       ate;
    logic       alive;
    logic       game_over;
    logic       q_head;
    logic       q_body;

    modport master (
        output move_tick, start, dir_valid, dir_req, apple_x, apple_y, q_x, q_y,
        input  head_x, head_y, length, ate, alive, game_over, q_head, q_body
    );

    modport slave (
        input  move_tick, start, dir_valid, dir_req, apple_x, apple_y, q_x, q_y,
        output head_x, head_y, length, ate, alive, game_over, q_head, q_body
    );
endinterface

// File: rtl/snake_body.sv
// Snake body: segment shift register, direction latch, growth on apple,
// wall/self collision, and a registered per-cell head/body query.
// Optional macro SNAKE_WRAP_EN: when defined the grid edges wrap around and
// only self collision ends the game; otherwise leaving the grid is fatal.
//
// state  | meaning
// S_IDLE | waiting for start, snake shown in its initial layout
// S_RUN  | snake advances one cell per move_tick
// S_DEAD | collision happened, everything frozen until start
module snake_body #(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic         clk,
    input  logic         reset,
    snake_body_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;
    localparam logic [6:0] X_MAX     = 7'(GRID_W - 1);
    localparam logic [5:0] Y_MAX     = 6'(GRID_H - 1);
    localparam logic [6:0] X_INIT    = 7'(GRID_W / 4);
    localparam logic [5:0] Y_INIT    = 6'(GRID_H / 2);
    localparam logic [4:0] LEN_INIT  = 5'(INIT_LEN);
    localparam logic [4:0] LEN_MAX   = 5'(MAX_LEN);
`ifdef SNAKE_WRAP_EN
    localparam logic       WRAP_EN   = 1'b1;
`else
    localparam logic       WRAP_EN   = 1'b0;
`endif

    state_t     state, state_nxt;
    logic [6:0] seg_x [MAX_LEN];
    logic [5:0] seg_y [MAX_LEN];
    logic [4:0] len;
    logic [1:0] dir, dir_pend, dir_eff;
    logic       ate_r, q_head_r, q_body_r;
    logic [6:0] nh_x;
    logic [5:0] nh_y;
    logic       wall_hit, self_hit, apple_hit, grow;
    logic       do_move, reload;
    logic       head_match, body_match;

    // Effective direction: a valid non-reversing request overrides the pending one
    always_comb begin
        dir_eff = dir_pend;
        if (bus.dir_valid && (bus.dir_req != (dir ^ 2'b10)))
            dir_eff = bus.dir_req;
    end

    // Next head position; edges are checked before any subtract/add so nothing wraps by accident
    always_comb begin
        nh_x     = seg_x[0];
        nh_y     = seg_y[0];
        wall_hit = 1'b0;
        case (dir_eff)
            DIR_UP: begin
                if (seg_y[0] == 6'd0) begin
                    if (WRAP_EN) nh_y = Y_MAX;
                    else         wall_hit = 1'b1;
                end else nh_y = seg_y[0] - 6'd1;
            end
            DIR_RIGHT: begin
                if (seg_x[0] == X_MAX) begin
                    if (WRAP_EN) nh_x = 7'd0;
                    else         wall_hit = 1'b1;
                end else nh_x = seg_x[0] + 7'd1;
            end
            DIR_DOWN: begin
                if (seg_y[0] == Y_MAX) begin
                    if (WRAP_EN) nh_y = 6'd0;
                    else         wall_hit = 1'b1;
                end else nh_y = seg_y[0] + 6'd1;
            end
            default: begin
                if (seg_x[0] == 7'd0) begin
                    if (WRAP_EN) nh_x = X_MAX;
                    else         wall_hit = 1'b1;
                end else nh_x = seg_x[0] - 7'd1;
            end
        endcase
    end

    // Apple and self collision; the tail only blocks when the body actually lengthens,
    // since otherwise it moves out of the way on this same move
    always_comb begin
        apple_hit = (nh_x == bus.apple_x) && (nh_y == bus.apple_y);
        grow      = apple_hit && (len < LEN_MAX);
        self_hit  = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (((5'(i) < len - 5'd1) || ((5'(i) == len - 5'd1) && grow)) &&
                (seg_x[i] == nh_x) && (seg_y[i] == nh_y))
                self_hit = 1'b1;
        end
    end

    // Query compare against head and active non-head segments
    always_comb begin
        head_match = (bus.q_x == seg_x[0]) && (bus.q_y == seg_y[0]);
        body_match = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((5'(i) < len) && (bus.q_x == seg_x[i]) && (bus.q_y == seg_y[i]))
                body_match = 1'b1;
        end
    end

    // FSM next state and move/reload decisions
    always_comb begin
        state_nxt = state;
        do_move   = 1'b0;
        reload    = 1'b0;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_RUN;
            S_RUN: begin
                if (bus.move_tick) begin
                    if (wall_hit || self_hit) state_nxt = S_DEAD;
                    else                      do_move   = 1'b1;
                end
            end
            S_DEAD: begin
                if (bus.start) begin
                    reload    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Segment storage, length, direction and the ate pulse
    always_ff @(posedge clk) begin
        ate_r <= 1'b0;
        if (!reset || reload) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? X_INIT - 7'(i) : 7'd0;
                seg_y[i] <= (i < INIT_LEN) ? Y_INIT : 6'd0;
            end
            len      <= LEN_INIT;
            dir      <= DIR_RIGHT;
            dir_pend <= DIR_RIGHT;
        end else if (do_move) begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
            if (grow) len <= len + 5'd1;
            ate_r    <= apple_hit;
            dir      <= dir_eff;
            dir_pend <= dir_eff;
        end else if (state != S_DEAD) begin
            dir_pend <= dir_eff;
        end
    end

    // Registered query results for the draw path
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_head_r <= 1'b0;
            q_body_r <= 1'b0;
        end else begin
            q_head_r <= head_match;
            q_body_r <= body_match;
        end
    end

    assign bus.head_x    = seg_x[0];
    assign bus.head_y    = seg_y[0];
    assign bus.length    = len;
    assign bus.ate       = ate_r;
    assign bus.alive     = (state == S_RUN);
    assign bus.game_over = (state == S_DEAD);
    assign bus.q_head    = q_head_r;
    assign bus.q_body    = q_body_r;
endmodule

// File: tb/tb_snake_body.sv
// Directed testbench for snake_body: reset, straight run, eating, direction
// handling, wall exit (or wrap with SNAKE_WRAP_EN), self collision, mid-run reset.
module tb_snake_body;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    snake_body_if bus();

    snake_body dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic req_dir(input logic [1:0] d);
        bus.dir_valid = 1'b1;
        bus.dir_req   = d;
        step();
        bus.dir_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++;
        if (bus.q_head !== 1'b0 || bus.q_body !== 1'b0) begin
            errors++;
            $display("FAIL reset_query: got head=%b body=%b want 0 0", bus.q_head, bus.q_body);
        end
        checks++;
        if (bus.ate !== 1'b0 || bus.game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got ate=%b game_over=%b want 0 0", bus.ate, bus.game_over);
        end
        reset = 1'b1;
        step();
        checks++;
        if (bus.head_x !== 7'd16 || bus.head_y !== 6'd24) begin
            errors++;
            $display("FAIL reset_head: got (%0d,%0d) want (16,24)", bus.head_x, bus.head_y);
        end
        checks++;
        if (bus.length !== 5'd3 || bus.alive !== 1'b0) begin
            errors++;
            $display("FAIL reset_len_alive: got len=%0d alive=%b want 3 0", bus.length, bus.alive);
        end
        repeat (4) tick();
        checks++;
        if (bus.head_x !== 7'd16 || bus.head_y !== 6'd24 || bus.alive !== 1'b0) begin
            errors++;
            $display("FAIL idle_ticks: got (%0d,%0d) alive=%b want (16,24) 0", bus.head_x, bus.head_y, bus.alive);
        end
    endtask

    task automatic test_run_straight();
        int ate_seen;
        ate_seen = 0;
        do_reset();
        bus.apple_x = 7'd40;
        bus.apple_y = 6'd40;
        pulse_start();
        checks++;
        if (bus.alive !== 1'b1) begin
            errors++;
            $display("FAIL start_alive: got %b want 1", bus.alive);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ate === 1'b1) ate_seen++;
        end
        checks++;
        if (bus.head_x !== 7'd21 || bus.head_y !== 6'd24) begin
            errors++;
            $display("FAIL straight_head: got (%0d,%0d) want (21,24)", bus.head_x, bus.head_y);
        end
        checks++;
        if (bus.length !== 5'd3 || ate_seen !== 0) begin
            errors++;
            $display("FAIL straight_len_ate: got len=%0d ate_seen=%0d want 3 0", bus.length, ate_seen);
        end
    endtask

    task automatic test_eat();
        do_reset();
        bus.apple_x = 7'd17;
        bus.apple_y = 6'd24;
        pulse_start();
        tick();
        checks++;
        if (bus.ate !== 1'b1 || bus.length !== 5'd4) begin
            errors++;
            $display("FAIL eat_pulse_len: got ate=%b len=%0d want 1 4", bus.ate, bus.length);
        end
        checks++;
        if (bus.head_x !== 7'd17 || bus.head_y !== 6'd24) begin
            errors++;
            $display("FAIL eat_head: got (%0d,%0d) want (17,24)", bus.head_x, bus.head_y);
        end
        bus.apple_x = 7'd40;
        bus.apple_y = 6'd40;
        bus.q_x = 7'd16;
        bus.q_y = 6'd24;
        step();
        checks++;
        if (bus.ate !== 1'b0) begin
            errors++;
            $display("FAIL eat_one_cycle: got ate=%b want 0", bus.ate);
        end
        checks++;
        if (bus.q_body !== 1'b1 || bus.q_head !== 1'b0) begin
            errors++;
            $display("FAIL query_body: got body=%b head=%b want 1 0", bus.q_body, bus.q_head);
        end
        bus.q_x = 7'd17;
        step();
        checks++;
        if (bus.q_head !== 1'b1 || bus.q_body !== 1'b0) begin
            errors++;
            $display("FAIL query_head: got head=%b body=%b want 1 0", bus.q_head, bus.q_body);
        end
        bus.q_x = 7'd0;
        bus.q_y = 6'd0;
    endtask

    task automatic test_direction();
        req_dir(2'b11);
        tick();
        checks++;
        if (bus.head_x !== 7'd18 || bus.head_y !== 6'd24) begin
            errors++;
            $display("FAIL reverse_ignored: got (%0d,%0d) want (18,24)", bus.head_x, bus.head_y);
        end
        req_dir(2'b00);
        tick();
        checks++;
        if (bus.head_x !== 7'd18 || bus.head_y !== 6'd23) begin
            errors++;
            $display("FAIL turn_up: got (%0d,%0d) want (18,23)", bus.head_x, bus.head_y);
        end
        bus.dir_valid = 1'b1;
        bus.dir_req   = 2'b01;
        tick();
        bus.dir_valid = 1'b0;
        checks++;
        if (bus.head_x !== 7'd19 || bus.head_y !== 6'd23) begin
            errors++;
            $display("FAIL same_cycle_turn: got (%0d,%0d) want (19,23)", bus.head_x, bus.head_y);
        end
        req_dir(2'b10);
        req_dir(2'b00);
        tick();
        checks++;
        if (bus.head_x !== 7'd19 || bus.head_y !== 6'd22) begin
            errors++;
            $display("FAIL last_request_wins: got (%0d,%0d) want (19,22)", bus.head_x, bus.head_y);
        end
    endtask

    task automatic test_wall();
        do_reset();
        bus.apple_x = 7'd40;
        bus.apple_y = 6'd40;
        pulse_start();
        repeat (47) tick();
        checks++;
        if (bus.head_x !== 7'd63 || bus.alive !== 1'b1) begin
            errors++;
            $display("FAIL reach_edge: got x=%0d alive=%b want 63 1", bus.head_x, bus.alive);
        end
        tick();
`ifdef SNAKE_WRAP_EN
        checks++;
        if (bus.head_x !== 7'd0 || bus.head_y !== 6'd24 || bus.alive !== 1'b1) begin
            errors++;
            $display("FAIL wrap_edge: got (%0d,%0d) alive=%b want (0,24) 1", bus.head_x, bus.head_y, bus.alive);
        end
`else
        checks++;
        if (bus.game_over !== 1'b1 || bus.alive !== 1'b0) begin
            errors++;
            $display("FAIL wall_dead: got game_over=%b alive=%b want 1 0", bus.game_over, bus.alive);
        end
        tick();
        checks++;
        if (bus.head_x !== 7'd63 || bus.head_y !== 6'd24 || bus.length !== 5'd3) begin
            errors++;
            $display("FAIL dead_frozen: got (%0d,%0d) len=%0d want (63,24) 3", bus.head_x, bus.head_y, bus.length);
        end
        pulse_start();
        checks++;
        if (bus.head_x !== 7'd16 || bus.head_y !== 6'd24 || bus.length !== 5'd3 ||
            bus.game_over !== 1'b0 || bus.alive !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle: got (%0d,%0d) len=%0d go=%b alive=%b want (16,24) 3 0 0",
                     bus.head_x, bus.head_y, bus.length, bus.game_over, bus.alive);
        end
`endif
    endtask

    task automatic test_self_collision();
        do_reset();
        bus.apple_x = 7'd17;
        bus.apple_y = 6'd24;
        pulse_start();
        tick();
        bus.apple_x = 7'd18;
        tick();
        checks++;
        if (bus.length !== 5'd5 || bus.ate !== 1'b1) begin
            errors++;
            $display("FAIL grow_to_5: got len=%0d ate=%b want 5 1", bus.length, bus.ate);
        end
        bus.apple_x = 7'd40;
        bus.apple_y = 6'd40;
        req_dir(2'b10);
        tick();
        req_dir(2'b11);
        tick();
        checks++;
        if (bus.head_x !== 7'd17 || bus.head_y !== 6'd25 || bus.alive !== 1'b1) begin
            errors++;
            $display("FAIL coil_pos: got (%0d,%0d) alive=%b want (17,25) 1", bus.head_x, bus.head_y, bus.alive);
        end
        req_dir(2'b00);
        tick();
        checks++;
        if (bus.game_over !== 1'b1 || bus.head_x !== 7'd17 || bus.head_y !== 6'd25 || bus.length !== 5'd5) begin
            errors++;
            $display("FAIL self_hit: got go=%b (%0d,%0d) len=%0d want 1 (17,25) 5",
                     bus.game_over, bus.head_x, bus.head_y, bus.length);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        pulse_start();
        tick();
        checks++;
        if (bus.head_x !== 7'd17 || bus.head_y !== 6'd24 || bus.alive !== 1'b1) begin
            errors++;
            $display("FAIL rerun_move: got (%0d,%0d) alive=%b want (17,24) 1", bus.head_x, bus.head_y, bus.alive);
        end
        bus.q_x = 7'd16;
        bus.q_y = 6'd24;
        bus.move_tick = 1'b1;
        reset = 1'b0;
        step();
        bus.move_tick = 1'b0;
        checks++;
        if (bus.head_x !== 7'd16 || bus.head_y !== 6'd24 || bus.length !== 5'd3 ||
            bus.alive !== 1'b0 || bus.q_body !== 1'b0 || bus.q_head !== 1'b0) begin
            errors++;
            $display("FAIL mid_run_reset: got (%0d,%0d) len=%0d alive=%b qb=%b qh=%b want (16,24) 3 0 0 0",
                     bus.head_x, bus.head_y, bus.length, bus.alive, bus.q_body, bus.q_head);
        end
        reset = 1'b1;
        step();
    endtask

    initial begin
        bus.move_tick = 1'b0;
        bus.start     = 1'b0;
        bus.dir_valid = 1'b0;
        bus.dir_req   = 2'b01;
        bus.apple_x   = 7'd40;
        bus.apple_y   = 6'd40;
        bus.q_x       = 7'd0;
        bus.q_y       = 6'd0;
        test_reset();
        test_run_straight();
        test_eat();
        test_direction();
        test_wall();
        test_self_collision();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/snake_body.md
Name: snake_body

Overview:
- Generates the snake's head position; the apple/score block consumes it, and this block consumes that block's apple position in return.
- Holds the snake body as a segment shift register and advances it one grid cell per move tick in the latched direction.
- Grows the body when the head lands on the apple; detects wall and self collision.
- Answers registered per-pixel-cell body/head hit queries for the draw path.

Parameters:
- GRID_W, 64, grid columns; x range 0..GRID_W-1.
- GRID_H, 48, grid rows; y range 0..GRID_H-1.
- MAX_LEN, 16, segment storage depth; maximum length.
- INIT_LEN, 3, length after reset/restart.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- move_tick  in  1  one-cycle pulse; advance snake one cell.
- start  in  1  one-cycle pulse; IDLE->RUN, DEAD->IDLE.
- dir_valid  in  1  dir_req qualifier.
- dir_req  in  2  00 up, 01 right, 10 down, 11 left.
- apple_x  in  7  apple column.
- apple_y  in  6  apple row.
- q_x  in  7  query column from draw path.
- q_y  in  6  query row from draw path.
- head_x  out  7  head column.
- head_y  out  6  head row.
- length  out  5  active segment count, including head.
- ate  out  1  one-cycle pulse on apple-eating move.
- alive  out  1  high in RUN.
- game_over  out  1  high in DEAD.
- q_head  out  1  query cell is the head (1-cycle latency).
- q_body  out  1  query cell is a non-head active segment (1-cycle latency).

Behaviour:
- Reset (reset=0 at clk edge, takes priority over every input):
  - state IDLE; segments seg0=(16,24), seg1=(15,24), seg2=(14,24); unused segments (0,0); length=INIT_LEN; dir=right; pending dir=right.
  - Outputs: head_x=16, head_y=24, length=3, ate=0, alive=0, game_over=0, q_head=0, q_body=0.
  - Reset mid-RUN restores the same state on the next edge.
- States:
  - IDLE: start -> RUN; move_tick ignored.
  - RUN: moves on move_tick; collision -> DEAD.
  - DEAD: everything frozen; start -> IDLE with the reset layout reloaded.
- Direction:
  - dir_valid latches dir_req into pending, except when it is the exact reverse of the current dir (ignored).
  - Pending is applied as dir at each move.
  - dir_valid and move_tick in the same cycle: the new request is used for that move; reversal check is against the current dir.
  - Last valid request before a tick wins.
- Move (RUN && move_tick):
  - Next head nh = seg0 + dir (up: y-1, down: y+1).
  - Wall collision: x would go below 0 or above GRID_W-1, or y below 0 or above GRID_H-1 -> DEAD; segments and length unchanged; no ate.
  - Self collision: nh equals any seg[i], 1 <= i < length. The tail seg[length-1] is excluded unless growing this move. -> DEAD.
  - Otherwise: seg[i] <= seg[i-1] for all i, and seg0 <= nh.
  - If nh == (apple_x, apple_y): length <= min(length+1, MAX_LEN); ate=1 for exactly that cycle. At MAX_LEN length saturates but ate still pulses.
  - Apple compare uses apple inputs sampled in the move cycle.
  - move_tick coincident with start in IDLE: state changes only, no move.
- Query path:
  - Registered compare of (q_x, q_y) against head and active segments.
  - Result appears the cycle after the query; valid in all states; both 0 during reset.
- Arithmetic: compare widths 7b x / 6b y; underflow detected before the subtract, never by wrap.

Optional Feature:
- Macro SNAKE_WRAP_EN.
- Defined: walls wrap (x GRID_W-1 -> 0, 0 -> GRID_W-1; same for y with GRID_H); only self collision ends the game.
- Undefined: wall exit -> DEAD as above.

Test Plan:
- reset=0 for 2 clks, release -> head (16,24), length 3, alive 0; 4 move_ticks in IDLE -> head unchanged.
- start, 5 ticks right, apple (40,40) -> head (21,24), length 3, ate never 1.
- apple (17,24), start, 1 tick -> head (17,24), length 4, ate high exactly 1 cycle; q_x=16,q_y=24 -> q_body=1 next cycle; q_x=17 -> q_head=1.
- Reversal: dir_req=11 (left) while moving right, tick -> head x+1, dir unchanged; dir_req=00 then tick -> y decreases by 1.
- Without SNAKE_WRAP_EN: move right until x=63, next tick -> game_over=1, head stays (63,24); start -> IDLE, head (16,24), length 3. With SNAKE_WRAP_EN: same tick -> head (0,24), alive stays 1.
- Grow to length 5 via apples, then turn down, left, up into the body -> DEAD on the colliding tick; reset=0 mid-RUN -> reset values next edge.
